// File: rtl/mem_param_pkg.sv
// Shared types and limits for the parametrised scratch memory.
package mem_param_pkg;

   typedef enum logic {CLEAR, READY} mem_state_e;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_param_if.sv
// Command/response bundle between a memory master and mem_param.
interface mem_param_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 5
);
   logic                  write;
   logic                  read;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  rd_valid;
   logic                  busy;
   logic                  err;

   modport master (
      output write, read, addr, data_in,
      input  data_out, rd_valid, busy, err
   );

   modport slave (
      input  write, read, addr, data_in,
      output data_out, rd_valid, busy, err
   );
endinterface

// File: rtl/mem_rd_pipe.sv
// Read-return shift register: STAGES registers of valid bit plus data,
// valid chain flushed synchronously on reset.
module mem_rd_pipe #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned STAGES     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data
);
   logic [STAGES-1:0]     r_valid;
   logic [DATA_WIDTH-1:0] r_data [STAGES];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
      end else begin
         r_valid[0] <= i_valid;
         for (int i = 1; i < STAGES; i++) begin
            r_valid[i] <= r_valid[i-1];
         end
      end
   end

   // Data needs no reset; only the valid chain qualifies it.
   always_ff @(posedge clk) begin
      r_data[0] <= i_data;
      for (int i = 1; i < STAGES; i++) begin
         r_data[i] <= r_data[i-1];
      end
   end

   assign o_valid = r_valid[STAGES-1];
   assign o_data  = r_data[STAGES-1];
endmodule

// File: rtl/mem_param.sv
// Parametrised single-port RAM with optional post-reset clear, configurable
// read latency with a valid strobe, and a registered error strobe.
module mem_param
   import mem_param_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned DEPTH          = 32,
   parameter int unsigned RD_LAT         = 1,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input logic        clk,
   input logic        reset,
   mem_param_if.slave bus
);
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX || DEPTH < 2) begin : g_bad_param
      $fatal(1, "mem_param: RD_LAT must be within 1..4 and DEPTH at least 2");
   end

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   mem_state_e            r_state;
   logic [ADDR_WIDTH-1:0] r_clr_ptr;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_rd_valid;
   logic                  r_err;

   logic                  w_ready;
   logic                  w_in_range;
   logic                  w_wr_ok;
   logic                  w_rd_ok;
   logic                  w_bad;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_pipe_valid;
   logic [DATA_WIDTH-1:0] w_pipe_data;

   assign w_ready    = (r_state == READY);
   assign w_in_range = (32'(bus.addr) < DEPTH);
   assign w_wr_ok    = w_ready & bus.write & ~bus.read & w_in_range;
   assign w_rd_ok    = w_ready & bus.read & ~bus.write & w_in_range;
   // Any command that is not a legal access counts as an error.
   assign w_bad      = (bus.write | bus.read) & ~(w_wr_ok | w_rd_ok);
   assign w_rd_data  = r_mem[bus.addr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
         end else if (w_wr_ok) begin
            r_mem[bus.addr] <= bus.data_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         r_clr_ptr  <= '0;
         r_data_out <= '0;
         r_rd_valid <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err      <= w_bad;
         r_rd_valid <= w_pipe_valid;
         if (w_pipe_valid) begin
            r_data_out <= w_pipe_data;
         end
         if (r_state == CLEAR) begin
            r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
            if (r_clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
               r_state <= READY;
            end
         end
      end
   end

   // RD_LAT-1 pipe stages after the sampling register, then the data_out register.
   mem_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .reset   (reset),
      .i_valid (w_rd_ok),
      .i_data  (w_rd_data),
      .o_valid (w_pipe_valid),
      .o_data  (w_pipe_data)
   );

   assign bus.data_out = r_data_out;
   assign bus.rd_valid = r_rd_valid;
   assign bus.busy     = (r_state == CLEAR);
   assign bus.err      = r_err;
endmodule

// File: tb/tb_mem_param.sv
// Directed bench for mem_param: a cleared 8x32 RD_LAT=2 instance and a
// non-power-of-2 16x20 RD_LAT=3 instance without clear.
module tb_mem_param;
   logic clk;
   logic rst0;
   logic rst1;
   int   n_checks;
   int   n_fail;

   mem_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) if0 ();
   mem_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) if1 ();

   mem_param #(
      .DATA_WIDTH     (8),
      .DEPTH          (32),
      .RD_LAT         (2),
      .CLEAR_ON_RESET (1)
   ) u_dut0 (
      .clk   (clk),
      .reset (rst0),
      .bus   (if0)
   );

   mem_param #(
      .DATA_WIDTH     (16),
      .DEPTH          (20),
      .RD_LAT         (3),
      .CLEAR_ON_RESET (0)
   ) u_dut1 (
      .clk   (clk),
      .reset (rst1),
      .bus   (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       wr;
      logic       rd;
      logic [4:0] addr;
      logic [7:0] din;
      logic       v;
      logic [7:0] dout;
      logic       e;
   } vec_t;

   vec_t tbl [20];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic drive0(input logic wr, input logic rd, input logic [4:0] a,
                         input logic [7:0] d);
      if0.write   = wr;
      if0.read    = rd;
      if0.addr    = a;
      if0.data_in = d;
   endtask

   task automatic drive1(input logic wr, input logic rd, input logic [4:0] a,
                         input logic [15:0] d);
      if1.write   = wr;
      if1.read    = rd;
      if1.addr    = a;
      if1.data_in = d;
   endtask

   task automatic chk0(input string tag, input logic v, input logic [7:0] d, input logic e);
      check($sformatf("%s_rd_valid", tag), if0.rd_valid, v);
      check($sformatf("%s_data_out", tag), if0.data_out, d);
      check($sformatf("%s_err", tag), if0.err, e);
   endtask

   task automatic chk1(input string tag, input logic v, input logic [15:0] d, input logic e);
      check($sformatf("%s_rd_valid", tag), if1.rd_valid, v);
      check($sformatf("%s_data_out", tag), if1.data_out, d);
      check($sformatf("%s_err", tag), if1.err, e);
   endtask

   // Reads addresses 0..31 back to back and expects word k == mult*k, two edges later.
   task automatic burst0(input int mult, input string tag);
      for (int c = 0; c < 34; c++) begin
         drive0(1'b0, (c < 32), 5'(c), 8'h00);
         tick();
         check($sformatf("%s_err%0d", tag, c), if0.err, 0);
         if (c >= 2) begin
            check($sformatf("%s_v%0d", tag, c), if0.rd_valid, 1);
            check($sformatf("%s_d%0d", tag, c), if0.data_out, 8'(mult * (c - 2)));
         end else begin
            check($sformatf("%s_v%0d", tag, c), if0.rd_valid, 0);
         end
      end
      drive0(1'b0, 1'b0, 5'd0, 8'h00);
      tick();
      chk0($sformatf("%s_hold", tag), 1'b0, 8'(mult * 31), 1'b0);
   endtask

   initial begin
      int n;
      n_checks = 0;
      n_fail   = 0;
      rst0 = 1'b1;
      rst1 = 1'b1;
      drive0(1'b0, 1'b1, 5'd0, 8'h00);
      drive1(1'b0, 1'b0, 5'd0, 16'h0000);

      tbl[0]  = '{1'b1, 1'b0, 5'd7,  8'hA5, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 5'd7,  8'h00, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 5'd4,  8'h44, 1'b0, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 8'hA5, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 5'd4,  8'hFF, 1'b0, 8'hA5, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 5'd4,  8'h00, 1'b0, 8'hA5, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 5'd4,  8'h55, 1'b0, 8'hA5, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 8'h44, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 5'd4,  8'h00, 1'b0, 8'h44, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 8'h44, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 8'h55, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 5'd9,  8'hFF, 1'b0, 8'h55, 1'b1};
      tbl[12] = '{1'b1, 1'b1, 5'd9,  8'hFF, 1'b0, 8'h55, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 8'h55, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 5'd31, 8'hC3, 1'b0, 8'h55, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 5'd31, 8'h00, 1'b0, 8'h55, 1'b0};
      tbl[16] = '{1'b0, 1'b1, 5'd7,  8'h00, 1'b0, 8'h55, 1'b0};
      tbl[17] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 8'hC3, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 8'hA5, 1'b0};
      tbl[19] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 8'hA5, 1'b0};

      // Instance 0: reset, then clear with a read held high throughout.
      tick();
      tick();
      chk0("rst0", 1'b0, 8'h00, 1'b0);
      check("rst0_busy", if0.busy, 1);
      rst0 = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         check($sformatf("clr_busy%0d", k), if0.busy, (k < 32));
         check($sformatf("clr_err%0d", k), if0.err, 1);
         check($sformatf("clr_v%0d", k), if0.rd_valid, 0);
      end
      burst0(0, "zero");

      for (int i = 0; i < 20; i++) begin
         drive0(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].din);
         tick();
         chk0($sformatf("vec%0d", i), tbl[i].v, tbl[i].dout, tbl[i].e);
      end

      for (int k = 0; k < 32; k++) begin
         drive0(1'b1, 1'b0, 5'(k), 8'(k * 3));
         tick();
         check($sformatf("fill_err%0d", k), if0.err, 0);
      end
      burst0(3, "pipe");

      // Reset again, abort the clear part-way, and time a complete restart.
      rst0 = 1'b1;
      drive0(1'b0, 1'b0, 5'd0, 8'h00);
      tick();
      chk0("rst0b", 1'b0, 8'h00, 1'b0);
      check("rst0b_busy", if0.busy, 1);
      rst0 = 1'b0;
      repeat (10) tick();
      check("midclr_busy", if0.busy, 1);
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      n = 0;
      while (if0.busy && n < 100) begin
         tick();
         n++;
      end
      check("clear_len", n, 32);
      drive0(1'b0, 1'b1, 5'd31, 8'h00);
      tick();
      drive0(1'b0, 1'b0, 5'd0, 8'h00);
      tick();
      check("reclr_v_early", if0.rd_valid, 0);
      tick();
      chk0("reclr_rd31", 1'b1, 8'h00, 1'b0);

      // Instance 1: DEPTH=20, 16-bit, RD_LAT=3, contents retained across reset.
      tick();
      chk1("rst1", 1'b0, 16'h0000, 1'b0);
      check("rst1_busy", if1.busy, 0);
      rst1 = 1'b0;
      drive1(1'b1, 1'b0, 5'd25, 16'hBEEF);
      tick();
      chk1("oor_wr", 1'b0, 16'h0000, 1'b1);
      drive1(1'b0, 1'b1, 5'd25, 16'h0000);
      tick();
      chk1("oor_rd", 1'b0, 16'h0000, 1'b1);
      drive1(1'b1, 1'b0, 5'd19, 16'h1234);
      tick();
      chk1("wr19", 1'b0, 16'h0000, 1'b0);
      drive1(1'b0, 1'b1, 5'd19, 16'h0000);
      tick();
      chk1("rd19_l0", 1'b0, 16'h0000, 1'b0);
      drive1(1'b0, 1'b0, 5'd0, 16'h0000);
      tick();
      chk1("oor_rd_novalid", 1'b0, 16'h0000, 1'b0);
      tick();
      chk1("rd19_l2", 1'b0, 16'h0000, 1'b0);
      tick();
      chk1("rd19_l3", 1'b1, 16'h1234, 1'b0);
      tick();
      chk1("rd19_hold", 1'b0, 16'h1234, 1'b0);

      drive1(1'b1, 1'b0, 5'd2, 16'h003C);
      tick();
      chk1("wr2", 1'b0, 16'h1234, 1'b0);
      drive1(1'b0, 1'b1, 5'd2, 16'h0000);
      tick();
      drive1(1'b0, 1'b0, 5'd0, 16'h0000);
      tick();
      chk1("rd2_l1", 1'b0, 16'h1234, 1'b0);
      rst1 = 1'b1;
      tick();
      chk1("midrd_rst", 1'b0, 16'h0000, 1'b0);
      check("midrd_rst_busy", if1.busy, 0);
      rst1 = 1'b0;
      tick();
      chk1("midrd_l3", 1'b0, 16'h0000, 1'b0);
      check("midrd_busy", if1.busy, 0);
      tick();
      chk1("midrd_l4", 1'b0, 16'h0000, 1'b0);
      drive1(1'b0, 1'b1, 5'd2, 16'h0000);
      tick();
      drive1(1'b0, 1'b0, 5'd0, 16'h0000);
      tick();
      tick();
      check("rd2b_l2", if1.rd_valid, 0);
      tick();
      chk1("rd2b_l3", 1'b1, 16'h003C, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
